// File: rtl/auth_ctrl_v2.sv
// Rider authorization and power-sequencing controller: decodes UART command
// bytes, debounces rider_off before power-down and counts unrecognized bytes.
module auth_ctrl_v2 #(
    parameter logic [7:0]  GO_CODE    = 8'h67,
    parameter logic [7:0]  STOP_CODE  = 8'h73,
    parameter logic [7:0]  ESTOP_CODE = 8'h78,
    parameter int unsigned OFF_DLY    = 1024,
    parameter int unsigned ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_rdy,
    input  logic             rider_off,
    output logic             clr_rx_rdy,
    output logic             pwr_up,
    output logic [1:0]       state_o,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned CW = $clog2(OFF_DLY + 1);
    localparam logic [CW-1:0] LAST = CW'(OFF_DLY);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PWR1 = 2'd1,
        PWR2 = 2'd2,
        DLY  = 2'd3
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;

    logic is_go;
    logic is_stop;
    logic is_estop;
    logic is_bad;

    assign is_go      = rx_rdy && (rx_data == GO_CODE);
    assign is_stop    = rx_rdy && (rx_data == STOP_CODE);
    assign is_estop   = rx_rdy && (rx_data == ESTOP_CODE);
    assign is_bad     = rx_rdy && !(is_go || is_stop || is_estop);

    assign clr_rx_rdy = rx_rdy && !rst;
    assign state_o    = state;

    always_comb begin
        nxt = state;
        case (state)
            OFF:  if (is_go) nxt = PWR1;
            PWR1: begin
                if (is_estop)     nxt = OFF;
                else if (is_stop) nxt = PWR2;
            end
            PWR2: begin
                if (is_estop)       nxt = OFF;
                else if (is_go)     nxt = PWR1;
                else if (rider_off) nxt = DLY;
            end
            DLY: begin
                // Count runs 0..OFF_DLY so power drops OFF_DLY+1 edges after DLY entry.
                if (is_estop)         nxt = OFF;
                else if (is_go)       nxt = PWR1;
                else if (!rider_off)  nxt = PWR2;
                else if (cnt == LAST) nxt = OFF;
            end
            default: nxt = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OFF;
            pwr_up  <= 1'b0;
            cnt     <= '0;
            err_cnt <= '0;
        end else begin
            state  <= nxt;
            pwr_up <= (nxt != OFF);
            cnt    <= (state == DLY && nxt == DLY) ? cnt + 1'b1 : '0;
            if (is_bad && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_auth_ctrl_v2.sv
// Scoreboard bench for auth_ctrl_v2: two instances (OFF_DLY=4 and 8) share
// stimulus; a reference model predicts each edge's outputs.
module tb_auth_ctrl_v2;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rider_off;

    logic       clr_a, pwr_a, clr_b, pwr_b;
    logic [1:0] st_a, st_b;
    logic [3:0] err_a, err_b;

    int checks   = 0;
    int failures = 0;

    auth_ctrl_v2 #(.OFF_DLY(4), .ERR_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rider_off(rider_off), .clr_rx_rdy(clr_a), .pwr_up(pwr_a),
        .state_o(st_a), .err_cnt(err_a)
    );

    auth_ctrl_v2 #(.OFF_DLY(8), .ERR_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rider_off(rider_off), .clr_rx_rdy(clr_b), .pwr_up(pwr_b),
        .state_o(st_b), .err_cnt(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pwr;
        logic [1:0] st;
        logic [3:0] err;
    } exp_t;

    exp_t exp_q[2][$];

    int         dly[2] = '{4, 8};
    logic [1:0] m_st[2];
    int         m_cnt[2];
    logic [3:0] m_err[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: advance one edge for instance i.
    task automatic model(input int i, input logic r, input logic rdy, input logic [7:0] d,
                         input logic roff);
        logic go, stp, es;
        go  = rdy && d == 8'h67;
        stp = rdy && d == 8'h73;
        es  = rdy && d == 8'h78;
        if (r) begin
            m_st[i] = 2'd0; m_cnt[i] = 0; m_err[i] = 4'd0;
            return;
        end
        if (rdy && !go && !stp && !es && m_err[i] < 4'd15) m_err[i] = m_err[i] + 4'd1;
        case (m_st[i])
            2'd0: if (go) m_st[i] = 2'd1;
            2'd1: if (es) m_st[i] = 2'd0; else if (stp) m_st[i] = 2'd2;
            2'd2: begin
                if (es) m_st[i] = 2'd0;
                else if (go) m_st[i] = 2'd1;
                else if (roff) begin m_st[i] = 2'd3; m_cnt[i] = 0; end
            end
            default: begin
                if (es)        begin m_st[i] = 2'd0; m_cnt[i] = 0; end
                else if (go)   begin m_st[i] = 2'd1; m_cnt[i] = 0; end
                else if (!roff) begin m_st[i] = 2'd2; m_cnt[i] = 0; end
                else if (m_cnt[i] + 1 > dly[i]) begin m_st[i] = 2'd0; m_cnt[i] = 0; end
                else m_cnt[i] = m_cnt[i] + 1;
            end
        endcase
    endtask

    task automatic step(input logic r, input logic rdy, input logic [7:0] d, input logic roff);
        exp_t e;
        exp_t ea;
        exp_t eb;
        rst = r; rx_rdy = rdy; rx_data = d; rider_off = roff;
        #1;
        check("clr_a", 32'(clr_a), 32'(rdy && !r));
        check("clr_b", 32'(clr_b), 32'(rdy && !r));
        for (int i = 0; i < 2; i++) begin
            model(i, r, rdy, d, roff);
            e.st = m_st[i]; e.pwr = (m_st[i] != 2'd0); e.err = m_err[i];
            exp_q[i].push_back(e);
        end
        @(posedge clk);
        #1;
        ea = exp_q[0].pop_front();
        eb = exp_q[1].pop_front();
        check("st_a",  32'(st_a),  32'(ea.st));
        check("pwr_a", 32'(pwr_a), 32'(ea.pwr));
        check("err_a", 32'(err_a), 32'(ea.err));
        check("st_b",  32'(st_b),  32'(eb.st));
        check("pwr_b", 32'(pwr_b), 32'(eb.pwr));
        check("err_b", 32'(err_b), 32'(eb.err));
    endtask

    task automatic idle(input logic roff);
        step(1'b0, 1'b0, 8'h00, roff);
    endtask

    task automatic byte_in(input logic [7:0] d, input logic roff);
        step(1'b0, 1'b1, d, roff);
    endtask

    // Hold rider_off high and count edges until each instance drops power.
    task automatic measure_fall(output int na, output int nb);
        na = 0; nb = 0;
        for (int k = 1; k <= 20; k++) begin
            idle(1'b1);
            if (!pwr_a && na == 0) na = k;
            if (!pwr_b && nb == 0) nb = k;
        end
    endtask

    initial begin
        int na, nb;
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rider_off = 1'b0;
        for (int i = 0; i < 2; i++) begin m_st[i] = 2'd0; m_cnt[i] = 0; m_err[i] = 4'd0; end

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h11, 1'b1);

        // GO powers up; rider_off ignored in OFF beforehand
        idle(1'b1);
        byte_in(8'h67, 1'b0);
        check("go_pwr", 32'(pwr_a), 32'd1);

        // STOP, then rider_off held: fall after OFF_DLY+1 edges
        byte_in(8'h73, 1'b0);
        idle(1'b1);
        check("dly_entry", 32'(st_a), 32'd3);
        measure_fall(na, nb);
        check("fall_edges_4", 32'(na), 32'd5);
        check("fall_edges_8", 32'(nb), 32'd9);

        // rider_off drops after 3 cycles in DLY, then count restarts
        byte_in(8'h67, 1'b0);
        byte_in(8'h73, 1'b0);
        idle(1'b1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        idle(1'b0);
        check("back_pwr2", 32'(st_b), 32'd2);
        idle(1'b1);
        measure_fall(na, nb);
        check("restart_4", 32'(na), 32'd5);
        check("restart_8", 32'(nb), 32'd9);

        // ESTOP in PWR1, PWR2, DLY, and in DLY with rider_off falling
        byte_in(8'h67, 1'b0); byte_in(8'h78, 1'b0);
        byte_in(8'h67, 1'b0); byte_in(8'h73, 1'b0); byte_in(8'h78, 1'b0);
        byte_in(8'h67, 1'b0); byte_in(8'h73, 1'b0); idle(1'b1); idle(1'b1); byte_in(8'h78, 1'b1);
        byte_in(8'h67, 1'b0); byte_in(8'h73, 1'b0); idle(1'b1); byte_in(8'h78, 1'b0);
        check("estop_off", 32'(pwr_a), 32'd0);

        // Ignored known bytes, GO from DLY, junk byte alongside rider_off
        byte_in(8'h73, 1'b0); byte_in(8'h78, 1'b0);
        byte_in(8'h67, 1'b0); byte_in(8'h67, 1'b0); byte_in(8'h73, 1'b0);
        byte_in(8'h73, 1'b0);
        byte_in(8'h42, 1'b1);
        check("junk_dly", 32'(st_a), 32'd3);
        idle(1'b1); byte_in(8'h67, 1'b1);
        byte_in(8'h78, 1'b0);

        // Error counter saturation
        for (int k = 0; k < 20; k++) byte_in(8'h00, 1'b0);
        check("err_sat", 32'(err_a), 32'd15);

        // Reset mid-count with simultaneous GO, then normal power-up
        byte_in(8'h67, 1'b0); byte_in(8'h73, 1'b0); idle(1'b1); idle(1'b1); idle(1'b1);
        step(1'b1, 1'b1, 8'h67, 1'b1);
        check("rst_err", 32'(err_a), 32'd0);
        byte_in(8'h67, 1'b0);
        check("post_rst_go", 32'(st_a), 32'd1);

        // Random mix of codes, junk and rider_off
        for (int k = 0; k < 300; k++) begin
            logic [7:0] d;
            case ($urandom_range(0, 4))
                0: d = 8'h67;
                1: d = 8'h73;
                2: d = 8'h78;
                default: d = 8'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), d,
                 ($urandom_range(0, 9) < 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
